// File: rtl/ps2_scan_rx_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    // Prefix bytes that modify the following scan code
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Frame decoder states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // One decoded key event as stored in the FIFO
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    // True when the eight data bits plus the parity bit hold an odd number of ones
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Event / status bundle between the PS/2 receiver and the key-handling logic.
interface ps2_scan_rx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    // Receiver side: produces events and status
    modport master (
        output ev_valid, ev_code, ev_ext, ev_break,
        output err_parity, err_frame, overflow,
        input  ev_ready
    );

    // Consumer side: accepts events and observes status
    modport slave (
        input  ev_valid, ev_code, ev_ext, ev_break,
        input  err_parity, err_frame, overflow,
        output ev_ready
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with a registered head entry.
// Pushes while full are ignored unless a pop happens in the same cycle.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  ps2_event_t din_i,
    input  logic       pop_i,
    output ps2_event_t head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    ps2_event_t    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q;
    ps2_event_t    head_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = empty_q;
    assign head_o  = head_q;

    // A pop frees its slot before a same-cycle push is considered
    assign pop_ok  = pop_i && !empty_q;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers, occupancy and registered head (bypass when writing into an empty FIFO)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            if (count_d != '0) begin
                head_q <= (push_ok && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
            end
        end
    end
endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: oversampled line conditioning, frame decode with
// parity/stop/timeout checks, E0/F0 prefix folding and an event FIFO.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_scan_rx_if.master ev_if
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // ---------------- input conditioning (index 0 = clock, 1 = data)
    logic [1:0] raw_lvl;
    logic [1:0] filt_lvl;
    logic [1:0] flip;

    assign raw_lvl = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic           sync1_q, sync2_q, filt_q;
            logic [FCW-1:0] cnt_q;
            logic           differs;

            assign differs      = (sync2_q != filt_q);
            assign flip[gi]     = differs && (cnt_q == FLT_LAST);
            assign filt_lvl[gi] = filt_q;

            // Two-flop synchronizer then a run-length filter on the synchronized level
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    filt_q  <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_lvl[gi];
                    sync2_q <= sync1_q;
                    if (flip[gi]) begin
                        filt_q <= sync2_q;
                        cnt_q  <= '0;
                    end else if (differs) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end
        end
    endgenerate

    logic fall;
    logic data_lvl;

    // Strobe on the cycle the filtered clock switches from high to low
    assign fall     = flip[0] && filt_lvl[0];
    assign data_lvl = filt_lvl[1];

    // ---------------- frame decoder
    ps2_state_e    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          good_q, good_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          timeout;

    assign timeout = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_LAST);

    // Frame FSM next-state, bit capture and error classification
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        good_d   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        to_cnt_d = (fall || (state_q == ST_IDLE)) ? '0 : to_cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_lvl) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                        shift_d = 8'h00;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d[idx_q] = data_lvl;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = data_lvl;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (!data_lvl) begin
                        ferr_d = 1'b1;
                    end else if (!ps2_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        good_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An idle line in the middle of a frame abandons it
        if (timeout) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end
    end

    // Frame decoder registers and registered error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            to_cnt_q <= '0;
            good_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            to_cnt_q <= to_cnt_d;
            good_q   <= good_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    // ---------------- prefix folding
    logic       pend_ext_q, pend_ext_d;
    logic       pend_brk_q, pend_brk_d;
    logic       is_prefix;
    logic       push;
    ps2_event_t ev_in;

    assign is_prefix = (shift_q == PS2_PFX_EXT) || (shift_q == PS2_PFX_BRK);
    assign push      = good_q && !is_prefix;
    assign ev_in     = {shift_q, pend_ext_q, pend_brk_q};

    // Prefix flags: set by E0/F0, consumed by a real code, dropped on any error
    always_comb begin
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;
        if (perr_d || ferr_d) begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
        end else if (good_q) begin
            if (shift_q == PS2_PFX_EXT) begin
                pend_ext_d = 1'b1;
            end else if (shift_q == PS2_PFX_BRK) begin
                pend_brk_d = 1'b1;
            end else begin
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
            end
        end
    end

    // ---------------- event buffer
    ps2_event_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       overflow_q, overflow_d;

    assign pop        = !fifo_empty && ev_if.ev_ready;
    assign overflow_d = overflow_q || (push && fifo_full && !pop);

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (ev_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Prefix flags and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
            overflow_q <= overflow_d;
        end
    end

    assign ev_if.ev_valid   = !fifo_empty;
    assign ev_if.ev_code    = head.code;
    assign ev_if.ev_ext     = head.ext;
    assign ev_if.ev_break   = head.brk;
    assign ev_if.err_parity = perr_q;
    assign ev_if.err_frame  = ferr_q;
    assign ev_if.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx with a queue-based event model.
module tb_ps2_scan_rx;
    import ps2_pkg::*;

    localparam int FL    = 4;
    localparam int TO    = 2000;
    localparam int DEPTH = 8;
    localparam int HALF  = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_scan_rx_if ev_if ();

    ps2_scan_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ev_if    (ev_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    ps2_event_t exp_q[$];
    logic m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
    int exp_perr = 0, exp_ferr = 0;
    int seen_perr = 0, seen_ferr = 0;
    int pops = 0;
    logic [7:0] last_code = 8'h00;
    logic last_ext = 1'b0, last_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model of a correctly framed byte
    task automatic model_good(input logic [7:0] c);
        ps2_event_t e;
        if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else begin
            e.code = c; e.ext = m_ext; e.brk = m_brk;
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    endtask

    // Drive n bits LSB first, data set up half a low-time before each falling clock
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF / 2);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
            tick(HALF / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] c, input logic bad_par, input logic stop_b);
        logic p;
        p = ~(^c) ^ bad_par;
        if (!stop_b) begin
            exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        end else if (bad_par) begin
            exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            model_good(c);
        end
        send_bits({stop_b, p, c, 1'b0}, 11);
        tick(20);
    endtask

    task automatic checkpoint(input string tag, input int exp_pops);
        check({tag, "_pops"}, pops, exp_pops);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_perr_cnt"}, seen_perr, exp_perr);
        check({tag, "_ferr_cnt"}, seen_ferr, exp_ferr);
        check({tag, "_overflow"}, ev_if.overflow, m_ovf);
    endtask

    // Per-cycle compare against the model
    logic prev_hold = 1'b0, prev_perr = 1'b0, prev_ferr = 1'b0;
    logic [7:0] prev_code = 8'h00;
    logic prev_ext = 1'b0, prev_brk = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0; prev_perr = 1'b0; prev_ferr = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_code", ev_if.ev_code, prev_code);
                check("hold_ext", ev_if.ev_ext, prev_ext);
                check("hold_break", ev_if.ev_break, prev_brk);
            end
            if (ev_if.ev_valid && ev_if.ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got code %0h ext %0b break %0b expected none",
                             ev_if.ev_code, ev_if.ev_ext, ev_if.ev_break);
                end else begin
                    ps2_event_t e;
                    e = exp_q.pop_front();
                    check("ev_code", ev_if.ev_code, e.code);
                    check("ev_ext", ev_if.ev_ext, e.ext);
                    check("ev_break", ev_if.ev_break, e.brk);
                end
                pops++;
                last_code = ev_if.ev_code;
                last_ext  = ev_if.ev_ext;
                last_brk  = ev_if.ev_break;
            end
            if (ev_if.err_parity) begin
                seen_perr++;
                check("err_parity_width", prev_perr, 0);
            end
            if (ev_if.err_frame) begin
                seen_ferr++;
                check("err_frame_width", prev_ferr, 0);
            end
            prev_perr = ev_if.err_parity;
            prev_ferr = ev_if.err_frame;
            prev_hold = ev_if.ev_valid && !ev_if.ev_ready;
            prev_code = ev_if.ev_code;
            prev_ext  = ev_if.ev_ext;
            prev_brk  = ev_if.ev_break;
        end
    end

    initial begin
        ev_if.ev_ready = 1'b1;
        rst = 1'b1;
        tick(5);
        check("rst_ev_valid", ev_if.ev_valid, 0);
        check("rst_ev_code", ev_if.ev_code, 0);
        check("rst_ev_ext", ev_if.ev_ext, 0);
        check("rst_ev_break", ev_if.ev_break, 0);
        check("rst_err_parity", ev_if.err_parity, 0);
        check("rst_err_frame", ev_if.err_frame, 0);
        check("rst_overflow", ev_if.overflow, 0);
        rst = 1'b0;
        tick(5);

        // plain make code
        send_byte(8'h1C, 1'b0, 1'b1);
        checkpoint("make_1c", 1);
        check("make_1c_code", last_code, 8'h1C);
        check("make_1c_ext", last_ext, 0);
        check("make_1c_brk", last_brk, 0);

        // break code
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        checkpoint("brk_1c", 2);
        check("brk_1c_code", last_code, 8'h1C);
        check("brk_1c_brk", last_brk, 1);
        check("brk_1c_ext", last_ext, 0);

        // extended break
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        checkpoint("ext_brk_75", 3);
        check("ext_brk_75_code", last_code, 8'h75);
        check("ext_brk_75_ext", last_ext, 1);
        check("ext_brk_75_brk", last_brk, 1);

        // parity error discards the byte and the pending E0
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b1, 1'b1);
        checkpoint("par_err", 3);
        check("par_err_literal", seen_perr, 1);
        send_byte(8'h1C, 1'b0, 1'b1);
        checkpoint("after_par", 4);
        check("after_par_ext", last_ext, 0);
        check("after_par_brk", last_brk, 0);

        // timeout on a partial frame
        exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        send_bits(11'b000_0000_1010, 4);
        tick(TO + 10);
        checkpoint("timeout", 4);
        check("timeout_literal", seen_ferr, 1);
        send_byte(8'h29, 1'b0, 1'b1);
        checkpoint("after_to", 5);
        check("after_to_code", last_code, 8'h29);

        // bad stop bit, then bad start bit
        send_byte(8'h33, 1'b0, 1'b0);
        checkpoint("bad_stop", 5);
        exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        send_bits(11'b1, 1);
        tick(20);
        checkpoint("bad_start", 5);
        check("bad_start_literal", seen_ferr, 3);

        // overflow with consumer stalled
        ev_if.ev_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i), 1'b0, 1'b1);
        check("ovf_set", ev_if.overflow, 1);
        check("ovf_model", m_ovf, 1);
        check("ovf_valid", ev_if.ev_valid, 1);
        check("ovf_head", ev_if.ev_code, 8'h01);
        ev_if.ev_ready = 1'b1;
        tick(20);
        checkpoint("drain", 5 + DEPTH);
        check("drain_last", last_code, 8'h08);
        check("drain_valid", ev_if.ev_valid, 0);
        check("drain_ovf_sticky", ev_if.overflow, 1);
        rst = 1'b1;
        model_reset();
        tick(3);
        check("rst_clears_ovf", ev_if.overflow, 0);
        check("rst_clears_valid", ev_if.ev_valid, 0);
        rst = 1'b0;
        tick(5);

        // reset mid-frame: no error pulse, next frame clean
        send_bits(11'b000_0000_0000, 5);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        send_byte(8'h2A, 1'b0, 1'b1);
        checkpoint("mid_rst", 6 + DEPTH);
        check("mid_rst_code", last_code, 8'h2A);
        check("mid_rst_ext", last_ext, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It oversamples the raw PS/2 clock and data lines, filters glitches, and decodes full 11-bit frames with odd-parity and stop-bit checks plus an inactivity timeout. It folds E0/F0 prefixes into single make/break events and buffers those events in a FIFO with a valid/ready output. It replaces the edge-clocked keyboard receiver and feeds the key-handling logic downstream.

## Interface
- FILTER_LEN, 4: consecutive identical samples required before the filtered PS/2 clock or data level changes (range 1–16).
- TIMEOUT_CYCLES, 50000: system cycles without a filtered falling clock edge before a partial frame is aborted. At 50 MHz this is 1 ms.
- FIFO_DEPTH, 8: number of event entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock. One clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- ev_valid  out  1  FIFO non-empty; head event presented.
- ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready.
- ev_code  out  8  scan code of the head event.
- ev_ext  out  1  head event was preceded by E0.
- ev_break  out  1  head event was preceded by F0 (key release).
- err_parity  out  1  one-cycle pulse on a parity failure.
- err_frame  out  1  one-cycle pulse on a bad start bit, bad stop bit, or timeout.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full. Cleared only by rst.

## Operation
- Input conditioning: each line passes through a 2-flop synchronizer, then a saturating filter of FILTER_LEN samples. A filtered falling clock edge is a one-cycle strobe `fall`. Reset state of both filtered levels is 1 (idle high).
- Frame FSM has states IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data=0 go to DATA with bit index 0. If data=1, pulse err_frame and stay in IDLE.
  - DATA: on each `fall`, shift data into bit[idx], LSB first. After idx 7, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, check the frame.
    - Stop bit is 0: err_frame.
    - Parity is not odd over 8 data bits plus the parity bit: err_parity.
    - Otherwise the byte is good.
    - Return to IDLE in every case. If both errors occur, only err_frame is pulsed.
- Timeout: a counter resets on every `fall`. If it reaches TIMEOUT_CYCLES while not in IDLE, go to IDLE, pulse err_frame, discard the partial byte, and clear the prefix flags.
- Prefix decode, applied to good bytes:
  - E0 sets pend_ext.
  - F0 sets pend_brk.
  - Any other code pushes {code, pend_ext, pend_brk} to the FIFO, then clears both flags.
  - Any error also clears both flags.
- FIFO: if a push arrives while full, drop the event and set overflow. A push and a pop in the same cycle while full are both legal; the pop frees the slot first.

## Timing
- Reset values: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, err_parity=0, err_frame=0, overflow=0. FSM is in IDLE, flags are clear, FIFO is empty.
- Latency from raw ps2_clk fall to `fall`: 2 synchronizer cycles plus FILTER_LEN cycles.
- The good-byte decision is registered one cycle after the STOP `fall`. The FIFO push happens on that same cycle. ev_valid rises on the following cycle.
- Error pulses are registered one cycle after the offending `fall` or after the timeout terminal count.
- Output fields are stable while ev_valid && !ev_ready. The head advances on the cycle after the accepting handshake.
- rst asserted mid-frame aborts the frame with no error pulse and empties the FIFO.

## Structure
- Shared package ps2_pkg holds:
  - the constants PS2_PFX_EXT = 8'hE0 and PS2_PFX_BRK = 8'hF0;
  - the FSM state enum;
  - a packed event struct {code[7:0], ext, brk}.
- One sub-module, ps2_event_fifo: a synchronous FIFO parametrised by FIFO_DEPTH and holding 10-bit entries, with full/empty and a registered head.
- Filter, FSM and prefix logic live in the top level.

## Test plan
- Frame 0x1C with parity 0 and stop 1, ev_ready=1 -> one event: code=1C, ext=0, break=0. No error pulses.
- Bytes F0, 1C -> exactly one event: code=1C, break=1, ext=0.
- Bytes E0, F0, 75 -> exactly one event: code=75, ext=1, break=1.
- Frame 0x1C with parity 1 -> err_parity pulses once and no event is pushed. A following plain 0x1C gives ext=0, break=0.
- Send start bit and 3 data bits, then hold the clock high for TIMEOUT_CYCLES+10 -> err_frame pulses once. The next full frame 0x29 is received correctly.
- With ev_ready=0, send FIFO_DEPTH+1 make codes 0x01..0x09 (depth 8) -> overflow=1. Draining yields 0x01..0x08 in order, and overflow stays 1 until rst.
